// File: rtl/pd_result_encoder.sv
// pd_result_encoder: serialises a winning nonce and its 256-bit hash into an
// 11-word result packet (header, nonce, H0..H7, XOR checksum) for the host link.
module pd_result_encoder #(
    parameter logic [7:0] HEADER_BYTE = 8'hA5,
    parameter logic [7:0] PKT_TYPE    = 8'h01,
    parameter bit         FLIP_ENDIAN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [31:0]  nonce,
    input  logic [255:0] hash,
    input  logic         tx_ready,
    output logic [31:0]  tx_data,
    output logic         tx_valid,
    output logic         busy,
    output logic         done
);

    localparam int unsigned NUM_WORDS = 11;
    localparam int unsigned LAST_IDX  = NUM_WORDS - 1;
    localparam int unsigned IDX_W     = 4;
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned HASH_WORDS = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [IDX_W-1:0]      r_idx;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic [IDX_W-1:0]      w_idx_inc;
    logic [WORD_W-1:0]     r_csum;
    logic [WORD_W-1:0]     w_csum_nxt;
    logic [WORD_W-1:0]     w_csum_upd;
    logic [WORD_W-1:0]     r_tx_data;
    logic [WORD_W-1:0]     w_data_nxt;
    logic [WORD_W-1:0]     w_word_nxt;
    logic [WORD_W-1:0]     w_header;
    logic                  r_tx_valid;
    logic                  r_busy;
    logic                  r_done;
    logic [7:0]            r_seq;
    logic [WORD_W-1:0]     r_nonce;
    logic [255:0]          r_hash;
    logic [WORD_W-1:0]     w_hword [HASH_WORDS];
    logic                  w_accept;
    logic                  w_hs;

    // Byte reversal of a payload word when the host expects the other endianness.
    function automatic logic [WORD_W-1:0] f_flip(input logic [WORD_W-1:0] w);
        if (FLIP_ENDIAN) begin
            return {w[7:0], w[15:8], w[23:16], w[31:24]};
        end
        return w;
    endfunction

    assign w_accept  = (r_state == S_IDLE) && start;
    assign w_hs      = r_tx_valid && tx_ready;
    assign w_idx_inc = r_idx + IDX_W'(1);
    assign w_csum_upd = r_csum ^ r_tx_data;
    assign w_header  = {HEADER_BYTE, PKT_TYPE, 8'(NUM_WORDS), r_seq};

    // Split the latched hash into H0..H7, H0 being the most significant word.
    always_comb begin
        for (int k = 0; k < int'(HASH_WORDS); k++) begin
            w_hword[k] = r_hash[WORD_W*(7-k) +: WORD_W];
        end
    end

    // Word to load after a handshake, selected by the incremented index; the
    // final word is the running checksum including the word just accepted.
    always_comb begin
        w_word_nxt = w_csum_upd;
        if (w_idx_inc == IDX_W'(1)) begin
            w_word_nxt = f_flip(r_nonce);
        end else if ((w_idx_inc >= IDX_W'(2)) && (w_idx_inc <= IDX_W'(9))) begin
            w_word_nxt = f_flip(w_hword[3'(w_idx_inc - IDX_W'(2))]);
        end
    end

    // Next-state, index, checksum and outgoing word.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_csum_nxt  = r_csum;
        w_data_nxt  = '0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_SEND;
                    w_idx_nxt   = '0;
                    w_csum_nxt  = '0;
                    w_data_nxt  = w_header;
                end
            end
            S_SEND: begin
                w_data_nxt = r_tx_data;
                if (w_hs) begin
                    if (r_idx == IDX_W'(LAST_IDX)) begin
                        w_state_nxt = S_DONE;
                        w_data_nxt  = '0;
                    end else begin
                        w_idx_nxt  = w_idx_inc;
                        w_csum_nxt = w_csum_upd;
                        w_data_nxt = w_word_nxt;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_csum     <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_csum     <= w_csum_nxt;
            r_tx_data  <= w_data_nxt;
            r_tx_valid <= (w_state_nxt == S_SEND);
            r_busy     <= (w_state_nxt != S_IDLE);
            r_done     <= (w_state_nxt == S_DONE);
        end
    end

    // Packet sequence number, advanced once per completed packet.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seq <= '0;
        end else if (r_state == S_DONE) begin
            r_seq <= r_seq + 8'd1;
        end
    end

    // Capture the result only when a new packet is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_nonce <= '0;
            r_hash  <= '0;
        end else if (w_accept) begin
            r_nonce <= nonce;
            r_hash  <= hash;
        end
    end

    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_pd_result_encoder.sv
// Directed bench for pd_result_encoder: one flipping and one non-flipping
// instance share the stimulus; expected packets come from a small model.
module tb_pd_result_encoder;

    logic         clk;
    logic         rst;
    logic         start;
    logic [31:0]  nonce;
    logic [255:0] hash;
    logic         tx_ready;
    logic [31:0]  tx_data_f;
    logic         tx_valid_f;
    logic         busy_f;
    logic         done_f;
    logic [31:0]  tx_data_n;
    logic         tx_valid_n;
    logic         busy_n;
    logic         done_n;

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [7:0]   exp_seq = 8'h00;

    pd_result_encoder #(.FLIP_ENDIAN(1'b1)) u_dut_flip (
        .clk(clk), .rst(rst), .start(start), .nonce(nonce), .hash(hash),
        .tx_ready(tx_ready), .tx_data(tx_data_f), .tx_valid(tx_valid_f),
        .busy(busy_f), .done(done_f)
    );

    pd_result_encoder #(.FLIP_ENDIAN(1'b0)) u_dut_noflip (
        .clk(clk), .rst(rst), .start(start), .nonce(nonce), .hash(hash),
        .tx_ready(tx_ready), .tx_data(tx_data_n), .tx_valid(tx_valid_n),
        .busy(busy_n), .done(done_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] bswap(input logic [31:0] w, input bit f);
        return f ? {w[7:0], w[15:8], w[23:16], w[31:24]} : w;
    endfunction

    // Model of one packet as it should appear on the link.
    task automatic build_pkt(input logic [31:0] n, input logic [255:0] h, input logic [7:0] seq,
                             input bit f, output logic [31:0] w [11]);
        logic [31:0] x;
        w[0] = {8'hA5, 8'h01, 8'h0B, seq};
        w[1] = bswap(n, f);
        for (int k = 0; k < 8; k++) begin
            w[2+k] = bswap(h[255-32*k -: 32], f);
        end
        x = 32'h0;
        for (int k = 0; k < 10; k++) x = x ^ w[k];
        w[10] = x;
    endtask

    // Sends one packet starting at the current negedge and checks every cycle of it.
    task automatic send_pkt(input logic [31:0] n, input logic [255:0] h, input bit stall,
                            input int restart_at, input bit poke_done);
        logic [31:0] ef [11];
        logic [31:0] en [11];
        int  nw = 0;
        int  cyc = 0;
        bit  fin = 1'b0;
        bit  restarted = 1'b0;
        build_pkt(n, h, exp_seq, 1'b1, ef);
        build_pkt(n, h, exp_seq, 1'b0, en);
        start = 1'b1; nonce = n; hash = h; tx_ready = 1'b1;
        while (!fin && cyc < 100) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (nw < 11) begin
                check_eq("tx_valid", 32'(tx_valid_f), 32'd1);
                check_eq("busy", 32'(busy_f), 32'd1);
                check_eq("tx_data_flip", tx_data_f, ef[nw]);
                check_eq("tx_data_noflip", tx_data_n, en[nw]);
                tx_ready = stall ? ((cyc % 3) == 1) : 1'b1;
                if (tx_ready) nw++;
                if (!restarted && restart_at >= 0 && nw == restart_at) begin
                    restarted = 1'b1;
                    start = 1'b1;
                    nonce = 32'hDEADBEEF;
                    hash  = ~h;
                end
            end else begin
                check_eq("done", 32'(done_f), 32'd1);
                check_eq("tx_valid_in_done", 32'(tx_valid_f), 32'd0);
                check_eq("busy_in_done", 32'(busy_f), 32'd1);
                check_eq("tx_data_in_done", tx_data_f, 32'h0);
                if (!stall) check_eq("done_cycle", 32'(cyc), 32'd12);
                if (poke_done) start = 1'b1;
                fin = 1'b1;
            end
        end
        check_eq("pkt_timeout", 32'(fin), 32'd1);
        @(negedge clk);
        start = 1'b0;
        check_eq("done_pulse_end", 32'(done_f), 32'd0);
        check_eq("busy_after_done", 32'(busy_f), 32'd0);
        check_eq("valid_after_done", 32'(tx_valid_f), 32'd0);
        exp_seq = exp_seq + 8'd1;
    endtask

    logic [255:0] h_t1;
    logic [255:0] h_r;

    initial begin
        rst = 1'b1; start = 1'b0; nonce = '0; hash = '0; tx_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_tx_valid", 32'(tx_valid_f), 32'd0);
        check_eq("rst_busy", 32'(busy_f), 32'd0);
        check_eq("rst_done", 32'(done_f), 32'd0);
        check_eq("rst_tx_data", tx_data_f, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        h_t1 = {32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7};
        // Basic packet, hand-known header and checksum, plus the unflipped instance.
        send_pkt(32'h11223344, h_t1, 1'b0, -1, 1'b0);
        // Ready toggling 1,0,0,1,...
        send_pkt(32'h11223344, h_t1, 1'b1, -1, 1'b0);
        // New start mid-packet with different inputs must be ignored.
        send_pkt(32'h11223344, h_t1, 1'b0, 4, 1'b0);

        // Reset in the middle of a packet.
        start = 1'b1; nonce = 32'hCAFEF00D; hash = ~h_t1; tx_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("busy_before_rst", 32'(busy_f), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort_tx_valid", 32'(tx_valid_f), 32'd0);
        check_eq("abort_busy", 32'(busy_f), 32'd0);
        check_eq("abort_done", 32'(done_f), 32'd0);
        check_eq("abort_tx_data", tx_data_f, 32'h0);
        exp_seq = 8'h00;

        // 257 back-to-back packets, seq wraps; start poked during each DONE cycle.
        for (int p = 0; p < 257; p++) begin
            h_r = {$urandom(), $urandom(), $urandom(), $urandom(),
                   $urandom(), $urandom(), $urandom(), $urandom()};
            send_pkt($urandom(), h_r, 1'b0, -1, 1'b1);
        end
        check_eq("seq_wrapped", 32'(exp_seq), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
